core_ex: RTL and testbench

- Execute stage. Consumes the registered ID/EX bundle and computes ALU, branch, jump and load/store-address results.
- Results are registered toward EX/MEM and write-back.
- Branch/jump redirects and pipeline-hold requests are issued back toward IF/ID/ID-EX.
- Shifts run on an area-saving serial shifter. While a shift is in progress, the stage holds the upstream pipeline.

---
 rtl/core_ex.sv | 266 ++++++++++++++++++++++++++
 tb/tb_core_ex.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ex.sv
// Execute stage: ALU, branch/jump redirect, load/store address generation and an
// optional multi-cycle serial shifter that stalls the upstream pipeline while busy.
module core_ex #(
    parameter int unsigned SERIAL_SHIFT = 1,
    parameter int unsigned SHIFT_STEP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_in,
    input  logic        reg_we_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] reg1_data_in,
    input  logic [31:0] reg2_data_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  func3_in,
    input  logic [6:0]  func7_in,
    input  logic [31:0] immI_in,
    input  logic [31:0] immS_in,
    input  logic [31:0] immB_in,
    input  logic [31:0] immU_in,
    input  logic [31:0] immJ_in,
    input  logic [4:0]  shamt_in,
    output logic        reg_we_out,
    output logic [4:0]  reg_write_addr_out,
    output logic [31:0] reg_write_data_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [2:0]  mem_func3_out,
    output logic        jump_flag_out,
    output logic [31:0] jump_addr_out,
    output logic        hold_flag_out
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    localparam logic [1:0] KindSll = 2'd0;
    localparam logic [1:0] KindSrl = 2'd1;
    localparam logic [1:0] KindSra = 2'd2;

    localparam logic [4:0] StepAmt = 5'(SHIFT_STEP);

    typedef enum logic {StIdle, StShift} state_e;

    function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [4:0] amt,
                                             input logic [1:0] kind);
        case (kind)
            KindSra: shift_by = 32'($signed(v) >>> amt);
            KindSrl: shift_by = v >> amt;
            default: shift_by = v << amt;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_hold_q, we_hold_d;

    logic        reg_we_q, reg_we_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  mem_func3_q, mem_func3_d;

    logic        is_op, is_opimm, is_shift, start_shift, wr_en, branch_taken;
    logic [31:0] alu_b, alu_res, pc_plus4;
    logic [4:0]  shamt_sel, step;
    logic [1:0]  shift_kind;
    logic [31:0] shifted;

    // Only func7[5] carries meaning in this stage.
    logic unused_func7;
    assign unused_func7 = ^{func7_in[6], func7_in[4:0]};

    assign is_op       = (opcode_in == OpcOp);
    assign is_opimm    = (opcode_in == OpcOpImm);
    assign alu_b       = is_op ? reg2_data_in : immI_in;
    assign shamt_sel   = is_op ? reg2_data_in[4:0] : shamt_in;
    assign is_shift    = (is_op || is_opimm) && (func3_in[1:0] == 2'b01);
    assign shift_kind  = func3_in[2] ? (func7_in[5] ? KindSra : KindSrl) : KindSll;
    assign start_shift = (SERIAL_SHIFT != 0) && is_shift && (shamt_sel != 5'd0);
    assign wr_en       = reg_we_in && (reg_write_addr_in != 5'd0);
    assign pc_plus4    = inst_addr_in + 32'd4;

    always_comb begin
        alu_res = '0;
        case (func3_in)
            3'b000:  alu_res = (is_op && func7_in[5]) ? reg1_data_in - alu_b
                                                      : reg1_data_in + alu_b;
            3'b010:  alu_res = {31'd0, $signed(reg1_data_in) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, reg1_data_in < alu_b};
            3'b100:  alu_res = reg1_data_in ^ alu_b;
            3'b110:  alu_res = reg1_data_in | alu_b;
            3'b111:  alu_res = reg1_data_in & alu_b;
            default: alu_res = shift_by(reg1_data_in, shamt_sel, shift_kind);
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (func3_in)
            3'b000:  branch_taken = (reg1_data_in == reg2_data_in);
            3'b001:  branch_taken = (reg1_data_in != reg2_data_in);
            3'b100:  branch_taken = ($signed(reg1_data_in) < $signed(reg2_data_in));
            3'b101:  branch_taken = ($signed(reg1_data_in) >= $signed(reg2_data_in));
            3'b110:  branch_taken = (reg1_data_in < reg2_data_in);
            3'b111:  branch_taken = (reg1_data_in >= reg2_data_in);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        kind_d        = kind_q;
        rd_d          = rd_q;
        we_hold_d     = we_hold_q;
        reg_we_d      = 1'b0;
        rd_out_d      = '0;
        wdata_d       = '0;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_func3_d   = '0;
        jump_flag_out = 1'b0;
        jump_addr_out = '0;
        hold_flag_out = 1'b0;
        step          = '0;
        shifted       = '0;

        case (state_q)
            StIdle: begin
                rd_out_d = reg_write_addr_in;
                case (opcode_in)
                    OpcOp, OpcOpImm: begin
                        if (start_shift) begin
                            acc_d         = reg1_data_in;
                            cnt_d         = shamt_sel;
                            kind_d        = shift_kind;
                            rd_d          = reg_write_addr_in;
                            we_hold_d     = wr_en;
                            hold_flag_out = 1'b1;
                            state_d       = StShift;
                        end else begin
                            reg_we_d = wr_en;
                            wdata_d  = alu_res;
                        end
                    end
                    OpcLui: begin
                        reg_we_d = wr_en;
                        wdata_d  = immU_in;
                    end
                    OpcAuipc: begin
                        reg_we_d = wr_en;
                        wdata_d  = inst_addr_in + immU_in;
                    end
                    OpcJal: begin
                        reg_we_d      = wr_en;
                        wdata_d       = pc_plus4;
                        jump_flag_out = 1'b1;
                        jump_addr_out = inst_addr_in + immJ_in;
                    end
                    OpcJalr: begin
                        reg_we_d      = wr_en;
                        wdata_d       = pc_plus4;
                        jump_flag_out = 1'b1;
                        jump_addr_out = (reg1_data_in + immI_in) & ~32'd1;
                    end
                    OpcBranch: begin
                        jump_flag_out = branch_taken;
                        jump_addr_out = inst_addr_in + immB_in;
                    end
                    OpcLoad, OpcStore: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (opcode_in == OpcStore);
                        mem_addr_d  = reg1_data_in + ((opcode_in == OpcStore) ? immS_in
                                                                               : immI_in);
                        mem_wdata_d = reg2_data_in;
                        mem_func3_d = func3_in;
                    end
                    default: ;
                endcase
            end
            StShift: begin
                step          = (cnt_q > StepAmt) ? StepAmt : cnt_q;
                shifted       = shift_by(acc_q, step, kind_q);
                acc_d         = shifted;
                cnt_d         = cnt_q - step;
                hold_flag_out = (cnt_q > StepAmt);
                // Last step: write back and let ID/EX advance on this same edge.
                if (!hold_flag_out) begin
                    reg_we_d = we_hold_q;
                    rd_out_d = rd_q;
                    wdata_d  = shifted;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rst) begin
            jump_flag_out = 1'b0;
            hold_flag_out = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            kind_q      <= KindSll;
            rd_q        <= '0;
            we_hold_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            rd_out_q    <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_func3_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            rd_q        <= rd_d;
            we_hold_q   <= we_hold_d;
            reg_we_q    <= reg_we_d;
            rd_out_q    <= rd_out_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_func3_q <= mem_func3_d;
        end
    end

    assign reg_we_out         = reg_we_q;
    assign reg_write_addr_out = rd_out_q;
    assign reg_write_data_out = wdata_q;
    assign mem_req_out        = mem_req_q;
    assign mem_we_out         = mem_we_q;
    assign mem_addr_out       = mem_addr_q;
    assign mem_wdata_out      = mem_wdata_q;
    assign mem_func3_out      = mem_func3_q;

endmodule

// File: tb/tb_core_ex.sv
// Bench for core_ex: directed scenarios plus randomized ALU/branch/memory/shift traffic
// on a SHIFT_STEP=1 and a SHIFT_STEP=4 instance, checked against an ISA-level model.
module tb_core_ex;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    logic        clk, rst;
    logic [31:0] pc, rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        we_in;
    logic [4:0]  rd_in, shamt;
    logic [6:0]  opc1, opc4, f7;
    logic [2:0]  f3;

    logic        o1_we, o1_mreq, o1_mwe, o1_jump, o1_hold;
    logic [4:0]  o1_rd;
    logic [31:0] o1_data, o1_maddr, o1_mwdata, o1_jaddr;
    logic [2:0]  o1_mf3;
    logic        o4_we, o4_mreq, o4_mwe, o4_jump, o4_hold;
    logic [4:0]  o4_rd;
    logic [31:0] o4_data, o4_maddr, o4_mwdata, o4_jaddr;
    logic [2:0]  o4_mf3;

    int checks = 0;
    int errors = 0;

    core_ex #(.SERIAL_SHIFT(1), .SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .inst_addr_in(pc), .reg_we_in(we_in), .reg_write_addr_in(rd_in),
        .reg1_data_in(rs1), .reg2_data_in(rs2), .opcode_in(opc1), .func3_in(f3),
        .func7_in(f7), .immI_in(imm_i), .immS_in(imm_s), .immB_in(imm_b), .immU_in(imm_u),
        .immJ_in(imm_j), .shamt_in(shamt), .reg_we_out(o1_we), .reg_write_addr_out(o1_rd),
        .reg_write_data_out(o1_data), .mem_req_out(o1_mreq), .mem_we_out(o1_mwe),
        .mem_addr_out(o1_maddr), .mem_wdata_out(o1_mwdata), .mem_func3_out(o1_mf3),
        .jump_flag_out(o1_jump), .jump_addr_out(o1_jaddr), .hold_flag_out(o1_hold)
    );

    core_ex #(.SERIAL_SHIFT(1), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .inst_addr_in(pc), .reg_we_in(we_in), .reg_write_addr_in(rd_in),
        .reg1_data_in(rs1), .reg2_data_in(rs2), .opcode_in(opc4), .func3_in(f3),
        .func7_in(f7), .immI_in(imm_i), .immS_in(imm_s), .immB_in(imm_b), .immU_in(imm_u),
        .immJ_in(imm_j), .shamt_in(shamt), .reg_we_out(o4_we), .reg_write_addr_out(o4_rd),
        .reg_write_data_out(o4_data), .mem_req_out(o4_mreq), .mem_we_out(o4_mwe),
        .mem_addr_out(o4_maddr), .mem_wdata_out(o4_mwdata), .mem_func3_out(o4_mf3),
        .jump_flag_out(o4_jump), .jump_addr_out(o4_jaddr), .hold_flag_out(o4_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input int kind);
        if (kind == 0) return v << n;
        if (kind == 1) return v >> n;
        return (v >> n) | (v[31] ? ~(32'hFFFFFFFF >> n) : 32'h0);
    endfunction

    // Returns {write enable, write data} as the ISA defines the instruction's result.
    function automatic logic [32:0] model_wb(input logic [6:0] op, input logic [2:0] fn3,
            input logic [6:0] fn7, input logic [31:0] a, input logic [31:0] b,
            input logic [4:0] sh, input logic [4:0] d, input logic w);
        logic [31:0] r, y;
        logic        wr;
        int          n;
        r = 0; wr = 0;
        y = (op == OP) ? b : imm_i;
        n = (op == OP) ? int'(b[4:0]) : int'(sh);
        if (op == OP || op == OPIMM) begin
            wr = 1;
            case (fn3)
                3'd0: r = (op == OP && fn7[5]) ? a - y : a + y;
                3'd1: r = ref_shift(a, n, 0);
                3'd2: r = ((a ^ 32'h80000000) < (y ^ 32'h80000000)) ? 32'd1 : 32'd0;
                3'd3: r = (a < y) ? 32'd1 : 32'd0;
                3'd4: r = a ^ y;
                3'd5: r = ref_shift(a, n, fn7[5] ? 2 : 1);
                3'd6: r = a | y;
                default: r = a & y;
            endcase
        end else if (op == LUI) begin
            wr = 1; r = imm_u;
        end else if (op == AUIPC) begin
            wr = 1; r = pc + imm_u;
        end else if (op == JAL || op == JALR) begin
            wr = 1; r = pc + 4;
        end
        return {wr && w && (d != 0), r};
    endfunction

    function automatic logic [32:0] model_redirect(input logic [6:0] op, input logic [2:0] fn3,
            input logic [31:0] a, input logic [31:0] b);
        logic t;
        if (op == JAL) return {1'b1, pc + imm_j};
        if (op == JALR) return {1'b1, (a + imm_i) & 32'hFFFFFFFE};
        if (op != BRANCH) return 33'd0;
        case (fn3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = !($signed(a) < $signed(b));
            3'd6: t = (a < b);
            3'd7: t = !(a < b);
            default: t = 0;
        endcase
        return {t, pc + imm_b};
    endfunction

    task automatic drive(input int sel, input logic [6:0] op, input logic [2:0] fn3,
            input logic [6:0] fn7, input logic [31:0] a, input logic [31:0] b,
            input logic [4:0] d, input logic w);
        opc1 = (sel == 1) ? op : 7'h00;
        opc4 = (sel == 4) ? op : 7'h00;
        f3 = fn3; f7 = fn7; rs1 = a; rs2 = b; rd_in = d; we_in = w;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Clocks a started shift until hold drops, recording what the DUT did on the way.
    task automatic run_shift(input int sel, output int cycles, output int holds,
            output bit clean, output bit done, output logic w, output logic [4:0] d,
            output logic [31:0] data);
        logic h;
        cycles = 0; holds = 0; clean = 1; done = 0; w = 0; d = 0; data = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            h = (sel == 4) ? o4_hold : o1_hold;
            if (h === 1'b1) holds++;
            if (((sel == 4) ? o4_jump : o1_jump) !== 1'b0) clean = 0;
            tick;
            cycles++;
            w    = (sel == 4) ? o4_we : o1_we;
            d    = (sel == 4) ? o4_rd : o1_rd;
            data = (sel == 4) ? o4_data : o1_data;
            if (h !== 1'b1) done = 1;
            else if (w !== 1'b0 || ((sel == 4) ? o4_mreq : o1_mreq) !== 1'b0) clean = 0;
        end
    endtask

    task automatic test_reset;
        drive(1, 7'h00, 0, 0, 0, 0, 0, 0);
        #12;
        checks++; if ({o1_we, o1_rd, o1_data, o1_mreq, o1_mwe, o1_maddr, o1_mwdata, o1_mf3,
                       o1_jump, o1_hold} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero we=%b data=%h", o1_we, o1_data);
        end
        @(negedge clk) rst = 1;
        tick;
        imm_i = 32'd9;
        drive(1, OPIMM, 0, 0, 0, 0, 3, 1);
        tick;
        checks++; if (o1_we !== 1 || o1_data !== 32'd9) begin
            errors++; $display("FAIL pre_reset_addi got we=%b data=%h want 1 9", o1_we, o1_data);
        end
        pc = 32'h40; imm_j = 32'h100;
        drive(1, JAL, 0, 0, 0, 0, 1, 1);
        #1;
        checks++; if (o1_jump !== 1 || o1_jaddr !== 32'h140) begin
            errors++; $display("FAIL jal_redirect got %b %h want 1 140", o1_jump, o1_jaddr);
        end
        #2 rst = 0;
        #1;
        checks++; if ({o1_we, o1_rd, o1_data, o1_mreq, o1_mwe, o1_maddr, o1_mwdata, o1_mf3,
                       o1_jump, o1_hold} !== '0) begin
            errors++; $display("FAIL async_reset got we=%b jump=%b data=%h want all 0",
                               o1_we, o1_jump, o1_data);
        end
        imm_i = 32'd5;
        drive(1, OPIMM, 0, 0, 0, 0, 1, 1);
        @(negedge clk) rst = 1;
        tick;
        checks++; if (o1_we !== 1 || o1_rd !== 5'd1 || o1_data !== 32'd5) begin
            errors++; $display("FAIL post_reset_addi got we=%b rd=%0d data=%h want 1 1 5",
                               o1_we, o1_rd, o1_data);
        end
    endtask

    task automatic test_serial_sra;
        int cyc, hl; bit cl, dn; logic w; logic [4:0] d; logic [31:0] data;
        shamt = 5'd4;
        drive(1, OPIMM, 3'b101, 7'b0100000, 32'h80000000, 32'h0, 5, 1);
        run_shift(1, cyc, hl, cl, dn, w, d, data);
        checks++; if (!dn) begin errors++; $display("FAIL sra_timeout got no completion"); end
        checks++; if (hl !== 4) begin errors++; $display("FAIL sra_hold got %0d want 4", hl); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL sra_latency got %0d want 5", cyc); end
        checks++; if (!cl) begin errors++; $display("FAIL sra_bubble got activity want none"); end
        checks++; if (w !== 1 || d !== 5'd5 || data !== 32'hF8000000) begin
            errors++; $display("FAIL sra_result got %b %0d %h want 1 5 f8000000", w, d, data);
        end
        imm_i = 32'h11;
        drive(1, OPIMM, 0, 0, 32'h10, 0, 6, 1);
        #1;
        checks++; if (o1_hold !== 0) begin errors++; $display("FAIL sra_next_hold got 1 want 0"); end
        tick;
        checks++; if (o1_we !== 1 || o1_rd !== 5'd6 || o1_data !== 32'h21) begin
            errors++; $display("FAIL sra_next got %b %0d %h want 1 6 21", o1_we, o1_rd, o1_data);
        end
    endtask

    task automatic test_step4_sll;
        int cyc, hl; bit cl, dn; logic w; logic [4:0] d; logic [31:0] data;
        shamt = 5'h1F;
        drive(4, OP, 3'b001, 7'h00, 32'h1, 32'h6, 9, 1);
        run_shift(4, cyc, hl, cl, dn, w, d, data);
        checks++; if (!dn || cyc !== 3) begin
            errors++; $display("FAIL sll4_latency got %0d want 3", cyc);
        end
        checks++; if (hl !== 2) begin errors++; $display("FAIL sll4_hold got %0d want 2", hl); end
        checks++; if (w !== 1 || d !== 5'd9 || data !== 32'h40) begin
            errors++; $display("FAIL sll4_result got %b %0d %h want 1 9 40", w, d, data);
        end
    endtask

    task automatic test_branch_jalr;
        pc = 32'h100; imm_b = 32'h20;
        drive(1, BRANCH, 3'b000, 0, 32'd7, 32'd7, 5, 1);
        #1;
        checks++; if (o1_jump !== 1 || o1_jaddr !== 32'h120) begin
            errors++; $display("FAIL beq_taken got %b %h want 1 120", o1_jump, o1_jaddr);
        end
        tick;
        checks++; if (o1_we !== 0) begin errors++; $display("FAIL beq_we got 1 want 0"); end
        drive(1, BRANCH, 3'b110, 0, 32'hFFFFFFFF, 32'd1, 5, 1);
        #1;
        checks++; if (o1_jump !== 0) begin errors++; $display("FAIL bltu_not_taken got 1 want 0"); end
        tick;
        pc = 32'h40; imm_i = 32'h10;
        drive(1, JALR, 0, 0, 32'h203, 0, 1, 1);
        #1;
        checks++; if (o1_jump !== 1 || o1_jaddr !== 32'h212) begin
            errors++; $display("FAIL jalr_target got %b %h want 1 212", o1_jump, o1_jaddr);
        end
        tick;
        checks++; if (o1_we !== 1 || o1_rd !== 5'd1 || o1_data !== 32'h44) begin
            errors++; $display("FAIL jalr_link got %b %0d %h want 1 1 44", o1_we, o1_rd, o1_data);
        end
    endtask

    task automatic test_store_x0;
        imm_s = 32'hFFFFFFFC;
        drive(1, STORE, 3'b010, 0, 32'h1000, 32'hDEADBEEF, 0, 0);
        tick;
        checks++; if (o1_mreq !== 1 || o1_mwe !== 1 || o1_maddr !== 32'hFFC ||
                      o1_mwdata !== 32'hDEADBEEF || o1_mf3 !== 3'b010 || o1_we !== 0) begin
            errors++; $display("FAIL sw got req=%b we=%b addr=%h wd=%h want 1 1 ffc deadbeef",
                               o1_mreq, o1_mwe, o1_maddr, o1_mwdata);
        end
        drive(1, OP, 0, 0, 32'd3, 32'd4, 0, 1);
        tick;
        checks++; if (o1_we !== 0) begin errors++; $display("FAIL add_x0 got we=1 want 0"); end
    endtask

    task automatic test_reset_mid_shift;
        bit wrote;
        shamt = 5'd20;
        drive(1, OPIMM, 3'b101, 7'b0100000, 32'h80000000, 0, 7, 1);
        tick; tick; tick;
        #2 rst = 0;
        #1;
        checks++; if (o1_hold !== 0 || o1_we !== 0 || o1_data !== 0) begin
            errors++; $display("FAIL midshift_reset got hold=%b we=%b want 0 0", o1_hold, o1_we);
        end
        drive(1, 7'h00, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1;
        wrote = 0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (o1_we !== 0) wrote = 1;
        end
        checks++; if (wrote) begin errors++; $display("FAIL midshift_no_wb got write want none"); end
        imm_i = 32'd3;
        drive(1, OPIMM, 0, 0, 0, 0, 2, 1);
        #1;
        checks++; if (o1_hold !== 0) begin errors++; $display("FAIL midshift_idle_hold got 1 want 0"); end
        tick;
        checks++; if (o1_we !== 1 || o1_data !== 32'd3) begin
            errors++; $display("FAIL midshift_idle got %b %h want 1 3", o1_we, o1_data);
        end
    endtask

    task automatic test_random_alu;
        logic [6:0] opcs [10];
        logic [6:0] op;
        logic [32:0] ewb, ejmp;
        bit emem;
        opcs = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, 7'h7F};
        for (int i = 0; i < 60; i++) begin
            op = opcs[$urandom_range(0, 9)];
            pc = $urandom; imm_i = $urandom; imm_s = $urandom; imm_b = $urandom;
            imm_u = $urandom; imm_j = $urandom; shamt = 5'($urandom);
            drive(1, op, 3'($urandom), 7'($urandom), $urandom, $urandom, 5'($urandom),
                  1'($urandom));
            if ($urandom_range(0, 3) == 0) rs2 = rs1;
            if ((op == OP || op == OPIMM) && f3[1:0] == 2'b01) f3 = 3'b000;
            ewb  = model_wb(op, f3, f7, rs1, rs2, shamt, rd_in, we_in);
            ejmp = model_redirect(op, f3, rs1, rs2);
            emem = (op == LOAD || op == STORE);
            #1;
            checks++; if (o1_jump !== ejmp[32] || (ejmp[32] && o1_jaddr !== ejmp[31:0])) begin
                errors++; $display("FAIL rnd_jump op=%b got %b %h want %b %h", op, o1_jump,
                                   o1_jaddr, ejmp[32], ejmp[31:0]);
            end
            tick;
            checks++; if (o1_we !== ewb[32] ||
                          (ewb[32] && (o1_data !== ewb[31:0] || o1_rd !== rd_in))) begin
                errors++; $display("FAIL rnd_wb op=%b f3=%0d got %b %h want %b %h", op, f3,
                                   o1_we, o1_data, ewb[32], ewb[31:0]);
            end
            checks++; if (o1_mreq !== emem || o1_mwe !== (op == STORE) ||
                          (emem && (o1_maddr !== rs1 + ((op == STORE) ? imm_s : imm_i) ||
                                    o1_mwdata !== rs2 || o1_mf3 !== f3))) begin
                errors++; $display("FAIL rnd_mem op=%b got req=%b addr=%h want %b", op, o1_mreq,
                                   o1_maddr, emem);
            end
        end
    endtask

    task automatic test_random_shift;
        int sel, amt, step, exp_lat, cyc, hl; bit cl, dn; logic w; logic [4:0] d;
        logic [31:0] data; logic [6:0] op; logic [32:0] ewb; int kind;
        for (int i = 0; i < 16; i++) begin
            sel  = (i % 2 == 0) ? 1 : 4;
            step = sel;
            amt  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31);
            kind = $urandom_range(0, 2);
            op   = $urandom_range(0, 1) ? OP : OPIMM;
            drive(sel, op, (kind == 0) ? 3'b001 : 3'b101, (kind == 2) ? 7'h20 : 7'h00,
                  $urandom, $urandom, 5'($urandom), 1'($urandom));
            if (op == OP) begin
                rs2[4:0] = 5'(amt); shamt = 5'($urandom);
            end else begin
                shamt = 5'(amt);
            end
            ewb     = model_wb(op, f3, f7, rs1, rs2, shamt, rd_in, we_in);
            exp_lat = (amt == 0) ? 1 : (amt + step - 1) / step + 1;
            run_shift(sel, cyc, hl, cl, dn, w, d, data);
            checks++; if (!dn || cyc !== exp_lat || hl !== exp_lat - 1 || !cl) begin
                errors++; $display("FAIL rnd_shift_timing step=%0d amt=%0d got lat=%0d hold=%0d want %0d %0d",
                                   step, amt, cyc, hl, exp_lat, exp_lat - 1);
            end
            checks++; if (w !== ewb[32] || (ewb[32] && (data !== ewb[31:0] || d !== rd_in))) begin
                errors++; $display("FAIL rnd_shift_data step=%0d amt=%0d kind=%0d got %b %h want %b %h",
                                   step, amt, kind, w, data, ewb[32], ewb[31:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; pc = 0; rs1 = 0; rs2 = 0; imm_i = 0; imm_s = 0; imm_b = 0; imm_u = 0;
        imm_j = 0; we_in = 0; rd_in = 0; shamt = 0; opc1 = 0; opc4 = 0; f3 = 0; f7 = 0;
        test_reset;
        test_serial_sra;
        test_step4_sll;
        test_branch_jalr;
        test_store_x0;
        test_reset_mid_shift;
        test_random_alu;
        test_random_shift;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
